// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, little-endian byte
// array with byte/half/word loads and stores, and a response held until accepted.
module dmem_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            ready_q;
    logic            valid_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic [7:0]      mem [DEPTH_BYTES];

    logic            idle;
    logic            enter_resp;
    logic            acc_we;
    logic [2:0]      acc_f3;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [32:0]     acc_size;
    logic            acc_illegal;
    logic            acc_misal;
    logic            acc_oor;
    logic            acc_err;
    logic [AW-1:0]   idx0, idx1, idx2, idx3;
    logic [7:0]      b0, b1, b2, b3;
    logic [31:0]     load_data;
    logic [31:0]     rsp_data;

    assign idle = (state_q == StIdle);

    // With no wait states the access happens on the accept edge, so decode straight from the
    // request inputs while idle and from the latched request otherwise.
    assign acc_we    = idle ? req_we_i     : we_q;
    assign acc_f3    = idle ? req_funct3_i : f3_q;
    assign acc_addr  = idle ? req_addr_i   : addr_q;
    assign acc_wdata = idle ? req_wdata_i  : wdata_q;

    assign enter_resp = (idle && req_valid_i && (WAIT_STATES == 0)) ||
                        ((state_q == StWait) && (cnt_q == CW'(WAIT_STATES - 1)));

    always_comb begin
        acc_size = 33'd4;
        case (acc_f3[1:0])
            2'b00:   acc_size = 33'd1;
            2'b01:   acc_size = 33'd2;
            default: acc_size = 33'd4;
        endcase
    end

    assign acc_illegal = acc_we ? (acc_f3 > 3'd2)
                                : ((acc_f3[1:0] == 2'b11) || (acc_f3 == 3'b110));
    assign acc_misal   = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                         ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign acc_oor     = ({1'b0, acc_addr} + acc_size) > 33'(DEPTH_BYTES);
    assign acc_err     = acc_illegal || acc_misal || acc_oor;

    assign idx0 = acc_addr[AW-1:0];
    assign idx1 = idx0 + AW'(1);
    assign idx2 = idx0 + AW'(2);
    assign idx3 = idx0 + AW'(3);
    assign b0   = mem[idx0];
    assign b1   = mem[idx1];
    assign b2   = mem[idx2];
    assign b3   = mem[idx3];

    always_comb begin
        load_data = 32'h0;
        case (acc_f3)
            3'b000:  load_data = {{24{b0[7]}}, b0};
            3'b001:  load_data = {{16{b1[7]}}, b1, b0};
            3'b010:  load_data = {b3, b2, b1, b0};
            3'b100:  load_data = {24'h0, b0};
            3'b101:  load_data = {16'h0, b1, b0};
            default: load_data = 32'h0;
        endcase
    end

    assign rsp_data = (acc_we || acc_err) ? 32'h0 : load_data;

    // Memory is not reset; it is written only on the edge entering RESP.
    always_ff @(posedge clk_i) begin
        if (enter_resp && acc_we && !acc_err) begin
            mem[idx0] <= acc_wdata[7:0];
            if (acc_f3[1:0] != 2'b00) begin
                mem[idx1] <= acc_wdata[15:8];
            end
            if (acc_f3[1:0] == 2'b10) begin
                mem[idx2] <= acc_wdata[23:16];
                mem[idx3] <= acc_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        f3_q    <= req_funct3_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        ready_q <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state_q <= StResp;
                            valid_q <= 1'b1;
                            rdata_q <= rsp_data;
                            err_q   <= acc_err;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (enter_resp) begin
                        cnt_q   <= '0;
                        state_q <= StResp;
                        valid_q <= 1'b1;
                        rdata_q <= rsp_data;
                        err_q   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        rdata_q <= 32'h0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule
